gpio_debounce: RTL
==================

Name: gpio_debounce

Overview:
Input conditioner between the chip pads and the gpio block's input path. Per pin it synchronises the raw pad level, filters glitches with a programmable stable-time counter, and produces a clean level plus single-cycle rise/fall pulses. A small dbus register slave configures the threshold and per-pin bypass and exposes sticky edge flags.

Parameters:
NUM_PINS, 8, number of conditioned pins
CNT_W, 16, debounce counter/threshold width
SYNC_STAGES, 2, synchroniser flops per pin (min 2)
DEFAULT_THRESH, 16'd1000, reset value of DEB_THRESH

Ports:
clk  input  1  system clock
rst_n  input  1  reset; asynchronous, active-low
deb_sel_i  input  1  dbus select for this slave
dbus2deb_i  input  type_dbus2peri_s  dbus request (addr, w_data, w_en, req)
deb2dbus_o  output  type_peri2dbus_s  dbus response (r_data, ack)
pad_i  input  NUM_PINS  raw asynchronous pad levels
pin_o  output  NUM_PINS  debounced levels, to gpio input path
rise_o  output  NUM_PINS  1-cycle pulse on debounced 0->1
fall_o  output  NUM_PINS  1-cycle pulse on debounced 1->0

Behaviour:
- Reset (async assert, sync deassert via normal clocking): sync chains, counters, pin_o, rise_o, fall_o, DEB_CTRL, DEB_EDGE, ack, r_data = 0; DEB_THRESH = DEFAULT_THRESH.
- Registers (offset in addr[7:0]):
  - DEB_CTRL 0x00: RW, [NUM_PINS-1:0] bypass per pin.
  - DEB_THRESH 0x04: RW, [CNT_W-1:0].
  - DEB_STATUS 0x08: RO, current pin_o.
  - DEB_EDGE 0x0C: [2*NUM_PINS-1:0] = {fall flags, rise flags}, sticky, write-1-to-clear.
  - Unmapped: reads return 0, writes ignored, still acked.
- Sync: s[i] = pad_i[i] after SYNC_STAGES flops.
- Per-pin FSM, two states:
  - STABLE: cnt = 0. If s != pin_o, go to COUNTING with cnt = 1.
  - COUNTING: if s == pin_o, return to STABLE and clear cnt (glitch rejected). Else if cnt >= eff_thresh, toggle pin_o, return to STABLE and clear cnt. Else cnt + 1.
  - eff_thresh = max(DEB_THRESH, 1). cnt saturates at all-ones.
- Latency: a pad change held stable for T = eff_thresh cycles appears on pin_o SYNC_STAGES + T cycles after the pad edge is sampled.
- Bypass = 1: pin_o[i] <= s[i] every cycle, FSM held in STABLE with cnt = 0. Clearing bypass resumes filtering from the current pin_o.
- rise_o/fall_o: registered, asserted in the same cycle pin_o changes, for exactly one cycle. Applies in bypass mode too.
- DEB_EDGE: set when the matching rise_o/fall_o asserts. If a W1C write and a set hit the same bit in the same cycle, set wins.
- Threshold written mid-count: the new value is used from the next cycle. The >= compare releases immediately if cnt already meets it.
- Bus handshake:
  - rd_req = req & ~w_en & deb_sel_i; wr_req = req & w_en & deb_sel_i.
  - When (rd_req | wr_req) & ~ack: the write takes effect at that clock edge, and ack plus r_data (for reads) are registered and presented the next cycle.
  - ack is high for one cycle, then r_data and ack return to 0. A request held high across ack is re-serviced only after ack drops.

Decomposition:
- gpio_defs.svh gains:
  - enum type_gpio_deb_regs_e (DEB_CTRL_R = 8'h00, DEB_THRESH_R = 8'h04, DEB_STATUS_R = 8'h08, DEB_EDGE_R = 8'h0C).
  - Reuse of type_dbus2peri_s and type_peri2dbus_s.
- Sub-module gpio_deb_pin: sync chain, counter, 2-state FSM and edge pulse for one pin.
  - Inputs: clk, rst_n, pad, bypass, thresh.
  - Outputs: level, rise, fall.
  - Instantiated NUM_PINS times in a generate loop.
- Top level holds the register file, edge flags and bus slave.

Test Plan:
- Reset, then read all four registers -> CTRL = 0, THRESH = 1000, STATUS = 0, EDGE = 0; ack asserts exactly 1 cycle after req, then 0.
- Write THRESH = 4; pad_i[0] 0->1 held -> pin_o[0] = 1 and rise_o[0] pulses at cycle 2 + 4 after the edge is sampled; EDGE reads 0x0001.
- THRESH = 4; pad_i[3] high for 3 cycles then low -> pin_o[3] stays 0, no pulses, EDGE unchanged.
- Write CTRL = 0x80; pad_i[7] toggles 1->0->1 every 2 cycles -> pin_o[7] follows with 2-cycle latency; rise and fall pulses each time; EDGE[15] and EDGE[7] set.
- Set EDGE[0] via rise, then write EDGE = 0x0001 in the same cycle as a new rise on pin 0 -> EDGE[0] remains 1; a later W1C with no edge clears it.
- Assert rst_n low mid-count (cnt = 2, THRESH = 4) -> outputs zero immediately (async); after release, the pad must be stable for the full 4 cycles again before pin_o changes.

Source files
------------

// File: rtl/gpio_debounce_pkg.sv
// Shared types for the gpio input debouncer: dbus request/response structs,
// register offsets and the per-pin filter state encoding.
package gpio_debounce_pkg;

  typedef struct packed {
    logic [31:0] addr;
    logic [31:0] w_data;
    logic        w_en;
    logic        req;
  } type_dbus2peri_s;

  typedef struct packed {
    logic [31:0] r_data;
    logic        ack;
  } type_peri2dbus_s;

  typedef enum logic [7:0] {
    DEB_CTRL_R   = 8'h00,
    DEB_THRESH_R = 8'h04,
    DEB_STATUS_R = 8'h08,
    DEB_EDGE_R   = 8'h0C
  } type_gpio_deb_regs_e;

  typedef enum logic {
    DEB_STABLE   = 1'b0,
    DEB_COUNTING = 1'b1
  } type_deb_state_e;

endpackage

// File: rtl/gpio_deb_pin.sv
// One conditioned pin: synchroniser, stable-time filter and registered
// rise/fall pulses aligned with the level change.
module gpio_deb_pin
  import gpio_debounce_pkg::*;
#(
  parameter int unsigned CNT_W       = 16,
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             pad,
  input  logic             bypass,
  input  logic [CNT_W-1:0] thresh,
  output logic             level,
  output logic             rise,
  output logic             fall
);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   s;
  type_deb_state_e        state_q, state_nxt;
  logic [CNT_W-1:0]       cnt_q, cnt_nxt;
  logic [CNT_W-1:0]       eff_thresh;
  logic                   level_nxt;

  assign s          = sync_q[SYNC_STAGES-1];
  assign eff_thresh = (thresh == '0) ? CNT_W'(1) : thresh;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q  <= '0;
      state_q <= DEB_STABLE;
      cnt_q   <= '0;
      level   <= 1'b0;
      rise    <= 1'b0;
      fall    <= 1'b0;
    end else begin
      sync_q  <= {sync_q[SYNC_STAGES-2:0], pad};
      state_q <= state_nxt;
      cnt_q   <= cnt_nxt;
      level   <= level_nxt;
      rise    <= level_nxt & ~level;
      fall    <= ~level_nxt & level;
    end
  end

  always_comb begin
    state_nxt = state_q;
    cnt_nxt   = cnt_q;
    level_nxt = level;
    if (bypass) begin
      state_nxt = DEB_STABLE;
      cnt_nxt   = '0;
      level_nxt = s;
    end else begin
      case (state_q)
        DEB_STABLE: begin
          cnt_nxt = '0;
          if (s != level) begin
            state_nxt = DEB_COUNTING;
            cnt_nxt   = CNT_W'(1);
          end
        end
        DEB_COUNTING: begin
          if (s == level) begin
            state_nxt = DEB_STABLE;
            cnt_nxt   = '0;
          end else if (cnt_q >= eff_thresh) begin
            level_nxt = ~level;
            state_nxt = DEB_STABLE;
            cnt_nxt   = '0;
          end else if (cnt_q != '1) begin
            cnt_nxt = cnt_q + CNT_W'(1);
          end
        end
      endcase
    end
  end

endmodule

// File: rtl/gpio_debounce.sv
// Pad input conditioner: per-pin debounce filters plus a dbus register slave
// for threshold, bypass control, live status and sticky edge flags.
module gpio_debounce
  import gpio_debounce_pkg::*;
#(
  parameter int unsigned     NUM_PINS       = 8,
  parameter int unsigned     CNT_W          = 16,
  parameter int unsigned     SYNC_STAGES    = 2,
  parameter logic [CNT_W-1:0] DEFAULT_THRESH = 16'd1000
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                deb_sel_i,
  input  type_dbus2peri_s     dbus2deb_i,
  output type_peri2dbus_s     deb2dbus_o,
  input  logic [NUM_PINS-1:0] pad_i,
  output logic [NUM_PINS-1:0] pin_o,
  output logic [NUM_PINS-1:0] rise_o,
  output logic [NUM_PINS-1:0] fall_o
);

  logic [NUM_PINS-1:0]   ctrl_q;
  logic [CNT_W-1:0]      thresh_q;
  logic [2*NUM_PINS-1:0] edge_q;
  logic [2*NUM_PINS-1:0] edge_clr;
  logic                  ack_q;
  logic [31:0]           rdata_q;
  logic [31:0]           rd_data;
  logic [7:0]            reg_addr;
  logic                  rd_req, wr_req, svc;
  logic                  unused;

  assign reg_addr = dbus2deb_i.addr[7:0];
  assign rd_req   = dbus2deb_i.req & ~dbus2deb_i.w_en & deb_sel_i;
  assign wr_req   = dbus2deb_i.req &  dbus2deb_i.w_en & deb_sel_i;
  assign svc      = (rd_req | wr_req) & ~ack_q;
  assign unused   = ^{dbus2deb_i.addr[31:8], dbus2deb_i.w_data};

  assign deb2dbus_o = {rdata_q, ack_q};

  for (genvar i = 0; i < NUM_PINS; i++) begin : g_pin
    gpio_deb_pin #(
      .CNT_W      (CNT_W),
      .SYNC_STAGES(SYNC_STAGES)
    ) u_pin (
      .clk   (clk),
      .rst_n (rst_n),
      .pad   (pad_i[i]),
      .bypass(ctrl_q[i]),
      .thresh(thresh_q),
      .level (pin_o[i]),
      .rise  (rise_o[i]),
      .fall  (fall_o[i])
    );
  end

  always_comb begin
    rd_data = '0;
    case (reg_addr)
      DEB_CTRL_R:   rd_data = 32'(ctrl_q);
      DEB_THRESH_R: rd_data = 32'(thresh_q);
      DEB_STATUS_R: rd_data = 32'(pin_o);
      DEB_EDGE_R:   rd_data = 32'(edge_q);
      default:      rd_data = '0;
    endcase
  end

  always_comb begin
    edge_clr = '0;
    if (svc && wr_req && reg_addr == DEB_EDGE_R) begin
      edge_clr = dbus2deb_i.w_data[2*NUM_PINS-1:0];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ctrl_q   <= '0;
      thresh_q <= DEFAULT_THRESH;
      edge_q   <= '0;
      ack_q    <= 1'b0;
      rdata_q  <= '0;
    end else begin
      // Set is ORed in after the clear so a same-cycle edge survives W1C.
      edge_q  <= (edge_q & ~edge_clr) | {fall_o, rise_o};
      ack_q   <= svc;
      rdata_q <= (svc && rd_req) ? rd_data : '0;
      if (svc && wr_req) begin
        if (reg_addr == DEB_CTRL_R)   ctrl_q   <= dbus2deb_i.w_data[NUM_PINS-1:0];
        if (reg_addr == DEB_THRESH_R) thresh_q <= dbus2deb_i.w_data[CNT_W-1:0];
      end
    end
  end

endmodule
